// File: rtl/speed_frame_decoder.sv
// speed_frame_decoder
//   Assembles 4-byte speed frames {HEADER, BCD hi, BCD lo, XOR checksum}
//   from a UART receiver's byte bus, validates them, latches the speed and
//   scans it onto a 4-digit active-low 7-segment display as HTU.t.
//
//   Optional feature: define BLANK_LEADING_ZEROS_EN to blank a zero hundreds
//   digit, and a zero tens digit that follows a blank hundreds digit.
//
// Ports
//   clk        sole clock
//   rst_n      synchronous active-low reset
//   msg[7:0]   last received byte, stable while noti is high
//   noti       byte-valid level; its rising edge is the byte strobe
//   seg[7:0]   {dp,g,f,e,d,c,b,a}, active-low
//   dig_sel    one-hot active-low digit enable (bit 3 = hundreds)
//   frame_ok   1-cycle pulse, frame accepted
//   frame_err  1-cycle pulse, checksum/BCD error or inter-byte timeout
module speed_frame_decoder #(
   parameter logic [7:0] HEADER      = 8'hA5,
   parameter int         SCAN_DIV    = 1024,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] msg,
   input  logic       noti,
   output logic [7:0] seg,
   output logic [3:0] dig_sel,
   output logic       frame_ok,
   output logic       frame_err
);
   localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_D0   = 2'd1;
   localparam logic [1:0] S_D1   = 2'd2;
   localparam logic [1:0] S_CHK  = 2'd3;

   // noti_q is the delayed copy of noti used for edge detection
   logic            noti_q, noti_d, stb;
   logic [1:0]      state_q, state_d;
   logic [7:0]      chk_q, chk_d, d0_q, d0_d, d1_q, d1_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [3:0][3:0] dig_q, dig_d;
   logic [SW-1:0]   scan_q, scan_d;
   logic [1:0]      k_q, k_d;
   logic [7:0]      seg_q, seg_d;
   logic [3:0]      dig_sel_q, dig_sel_d;
   logic            ok_q, ok_d, err_q, err_d;
   logic            bcd_ok, blank;
   logic [3:0]      cur;

   function automatic logic [7:0] seg_decode(input logic [3:0] v);
      case (v)
         4'd0: return 8'hC0;
         4'd1: return 8'hF9;
         4'd2: return 8'hA4;
         4'd3: return 8'hB0;
         4'd4: return 8'h99;
         4'd5: return 8'h92;
         4'd6: return 8'h82;
         4'd7: return 8'hF8;
         4'd8: return 8'h80;
         4'd9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   // frame assembly, validation and inter-byte timeout
   always_comb begin
      noti_d  = noti;
      stb     = noti & ~noti_q;
      state_d = state_q;
      chk_d   = chk_q;
      d0_d    = d0_q;
      d1_d    = d1_q;
      dig_d   = dig_q;
      tmo_d   = tmo_q;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      bcd_ok  = (d0_q[7:4] <= 4'd9) && (d0_q[3:0] <= 4'd9) &&
                (d1_q[7:4] <= 4'd9) && (d1_q[3:0] <= 4'd9);
      if (state_q == S_IDLE) begin
         tmo_d = '0;
         if (stb && msg == HEADER) begin
            chk_d   = HEADER;
            state_d = S_D0;
         end
      end else if (stb) begin
         // a strobe in the same cycle as the timeout limit takes priority
         tmo_d = '0;
         case (state_q)
            S_D0: begin
               d0_d    = msg;
               chk_d   = chk_q ^ msg;
               state_d = S_D1;
            end
            S_D1: begin
               d1_d    = msg;
               chk_d   = chk_q ^ msg;
               state_d = S_CHK;
            end
            default: begin
               if (msg == chk_q && bcd_ok) begin
                  dig_d[3] = d0_q[7:4];
                  dig_d[2] = d0_q[3:0];
                  dig_d[1] = d1_q[7:4];
                  dig_d[0] = d1_q[3:0];
                  ok_d     = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = S_IDLE;
            end
         endcase
      end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
         err_d   = 1'b1;
         tmo_d   = '0;
         state_d = S_IDLE;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   // display scan; outputs are registered from the current slot
   always_comb begin
      if (scan_q == SW'(SCAN_DIV - 1)) begin
         scan_d = '0;
         k_d    = k_q + 2'd1;
      end else begin
         scan_d = scan_q + SW'(1);
         k_d    = k_q;
      end
      cur = dig_q[k_q];
`ifdef BLANK_LEADING_ZEROS_EN
      blank = ((k_q == 2'd3) && (dig_q[3] == 4'd0)) ||
              ((k_q == 2'd2) && (dig_q[3] == 4'd0) && (dig_q[2] == 4'd0));
`else
      blank = 1'b0;
`endif
      seg_d = blank ? 8'hFF : seg_decode(cur);
      // decimal point sits after the units digit
      if (k_q == 2'd1) seg_d[7] = 1'b0;
      dig_sel_d = ~(4'b0001 << k_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         noti_q    <= 1'b0;
         state_q   <= S_IDLE;
         chk_q     <= '0;
         d0_q      <= '0;
         d1_q      <= '0;
         tmo_q     <= '0;
         dig_q     <= '0;
         scan_q    <= '0;
         k_q       <= '0;
         seg_q     <= 8'hFF;
         dig_sel_q <= 4'b1111;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         noti_q    <= noti_d;
         state_q   <= state_d;
         chk_q     <= chk_d;
         d0_q      <= d0_d;
         d1_q      <= d1_d;
         tmo_q     <= tmo_d;
         dig_q     <= dig_d;
         scan_q    <= scan_d;
         k_q       <= k_d;
         seg_q     <= seg_d;
         dig_sel_q <= dig_sel_d;
         ok_q      <= ok_d;
         err_q     <= err_d;
      end
   end

   assign seg       = seg_q;
   assign dig_sel   = dig_sel_q;
   assign frame_ok  = ok_q;
   assign frame_err = err_q;
endmodule

// File: tb/tb_speed_frame_decoder.sv
// Testbench for speed_frame_decoder: directed scenarios plus randomized
// frames, checked against a byte-queue reference model of the frame rules.
module tb_speed_frame_decoder;
   localparam int         SCAN = 8;
   localparam int         TMO  = 200;
   localparam logic [7:0] HDR  = 8'hA5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] msg = 8'h00;
   logic       noti = 1'b0;
   logic [7:0] seg;
   logic [3:0] dig_sel;
   logic       frame_ok, frame_err;

   int n_checks = 0;
   int n_fail   = 0;
   int mon_ok   = 0;
   int mon_err  = 0;
   int exp_ok_tot  = 0;
   int exp_err_tot = 0;

   // reference model state
   logic [7:0] mq[$];
   int         exp_dig[4];
   logic [7:0] seg_tab[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   speed_frame_decoder #(.HEADER(HDR), .SCAN_DIV(SCAN), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .msg(msg), .noti(noti),
      .seg(seg), .dig_sel(dig_sel), .frame_ok(frame_ok), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_ok)  mon_ok++;
         if (frame_err) mon_err++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic model_clear();
      mq.delete();
      for (int i = 0; i < 4; i++) exp_dig[i] = 0;
   endtask

   // frame rules: header opens a frame, next three bytes complete it
   task automatic model_byte(input logic [7:0] b, output bit ok, output bit err);
      int x, good;
      ok = 0; err = 0;
      if (mq.size() == 0) begin
         if (b == HDR) mq.push_back(b);
         return;
      end
      mq.push_back(b);
      if (mq.size() == 4) begin
         x = int'(mq[0]) ^ int'(mq[1]) ^ int'(mq[2]);
         good = (x == int'(mq[3]));
         for (int i = 1; i <= 2; i++)
            if (int'(mq[i]) / 16 > 9 || int'(mq[i]) % 16 > 9) good = 0;
         if (good != 0) begin
            exp_dig[3] = int'(mq[1]) / 16;
            exp_dig[2] = int'(mq[1]) % 16;
            exp_dig[1] = int'(mq[2]) / 16;
            exp_dig[0] = int'(mq[2]) % 16;
            ok = 1;
         end else begin
            err = 1;
         end
         mq.delete();
      end
   endtask

   function automatic logic [7:0] exp_seg(input int k);
      logic [7:0] s;
      s = seg_tab[exp_dig[k]];
`ifdef BLANK_LEADING_ZEROS_EN
      if (k == 3 && exp_dig[3] == 0) s = 8'hFF;
      if (k == 2 && exp_dig[3] == 0 && exp_dig[2] == 0) s = 8'hFF;
`endif
      if (k == 1) s[7] = 1'b0;
      return s;
   endfunction

   // one byte: noti high for hi clocks then low for lo clocks; the pulse
   // outputs are checked one clock after the strobe
   task automatic send(input logic [7:0] b, input int hi, input int lo, input string nm);
      bit eok, eerr;
      model_byte(b, eok, eerr);
      if (eok) exp_ok_tot++;
      if (eerr) exp_err_tot++;
      @(negedge clk);
      msg = b; noti = 1'b1;
      @(negedge clk);
      n_checks++;
      if (frame_ok !== eok || frame_err !== eerr) begin
         n_fail++;
         $display("FAIL %s byte %02h: frame_ok=%0b frame_err=%0b, expected %0b/%0b",
                  nm, b, frame_ok, frame_err, eok, eerr);
      end
      repeat (hi - 1) @(negedge clk);
      noti = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d0, input logic [7:0] d1, input int hi,
                             input int lo, input string nm);
      send(HDR, hi, lo, nm);
      send(d0, hi, lo, nm);
      send(d1, hi, lo, nm);
      send(HDR ^ d0 ^ d1, hi, lo, nm);
   endtask

   // walks one full scan from the hundreds slot back round to it
   task automatic check_display(input string nm);
      int t, d;
      logic [3:0] ds;
      t = 0;
      while (dig_sel !== 4'b0111 && t < 8 * SCAN) begin @(negedge clk); t++; end
      while (dig_sel !== 4'b1110 && t < 8 * SCAN) begin @(negedge clk); t++; end
      if (t >= 8 * SCAN) begin
         n_checks++; n_fail++;
         $display("FAIL %s scan: dig_sel stuck at %b, expected it to cycle", nm, dig_sel);
         return;
      end
      for (int k = 0; k < 4; k++) begin
         ds = ~(4'b0001 << k);
         n_checks++;
         if (dig_sel !== ds || seg !== exp_seg(k)) begin
            n_fail++;
            $display("FAIL %s digit %0d: dig_sel=%b seg=%02h, expected %b/%02h",
                     nm, k, dig_sel, seg, ds, exp_seg(k));
         end
         d = 0;
         while (dig_sel === ds && d < 4 * SCAN) begin @(negedge clk); d++; end
         n_checks++;
         if (d != SCAN) begin
            n_fail++;
            $display("FAIL %s dwell digit %0d: %0d clocks, expected %0d", nm, k, d, SCAN);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; noti = 1'b0;
      repeat (2) @(negedge clk);
      model_clear();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bit eok, eerr;
      rst_n = 1'b0; noti = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (seg !== 8'hFF || dig_sel !== 4'b1111 || frame_ok !== 1'b0 || frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset values: seg=%02h dig_sel=%b ok=%b err=%b, expected FF/1111/0/0",
                  seg, dig_sel, frame_ok, frame_err);
      end
      // header already presented while reset releases -> strobe in first cycle
      msg = HDR; noti = 1'b1;
      model_clear();
      model_byte(HDR, eok, eerr);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (dig_sel !== 4'b1110 || seg !== 8'hC0) begin
         n_fail++;
         $display("FAIL first clock: dig_sel=%b seg=%02h, expected 1110/C0", dig_sel, seg);
      end
      @(negedge clk);
      noti = 1'b0;
      repeat (2) @(negedge clk);
      send(8'h12, 2, 2, "noti_at_release");
      send(8'h34, 2, 2, "noti_at_release");
      send(8'h83, 2, 2, "noti_at_release");
   endtask

   task automatic test_basic();
      do_reset();
      send_frame(8'h12, 8'h34, 3, 3, "basic");
      check_display("basic");
   endtask

   task automatic test_errors();
      do_reset();
      send(8'h55, 2, 2, "ignore_junk");
      send(HDR, 2, 2, "chk_err");
      send(8'h12, 2, 2, "chk_err");
      send(8'h34, 2, 2, "chk_err");
      send(8'h84, 2, 2, "chk_err");
      check_display("chk_err");
      // A5^1A^34 = 8B: checksum correct, only the A nibble is illegal
      send(HDR, 2, 2, "bcd_err");
      send(8'h1A, 2, 2, "bcd_err");
      send(8'h34, 2, 2, "bcd_err");
      send(8'h8B, 2, 2, "bcd_err");
      check_display("bcd_err");
      // header value inside a frame is plain data (no resync)
      send_frame(HDR, 8'h12, 2, 2, "hdr_as_data");
   endtask

   task automatic test_timeout();
      int e0;
      do_reset();
      send(HDR, 2, 2, "timeout");
      send(8'h12, 2, 2, "timeout");
      e0 = mon_err;
      repeat (TMO + 20) @(negedge clk);
      n_checks++;
      if (mon_err - e0 != 1) begin
         n_fail++;
         $display("FAIL timeout pulses: %0d, expected 1", mon_err - e0);
      end
      mq.delete();
      exp_err_tot++;
      send_frame(8'h12, 8'h34, 2, 2, "after_timeout");
      check_display("after_timeout");
      // each gap just under the limit; the counter restarts on every byte
      send_frame(8'h98, 8'h76, 2, TMO - 8, "slow_frame");
      check_display("slow_frame");
   endtask

   task automatic test_leading_zeros();
      send_frame(8'h00, 8'h50, 2, 2, "lead_zero");
      check_display("lead_zero");
      send_frame(8'h05, 8'h50, 2, 2, "lead_zero_tens");
      check_display("lead_zero_tens");
   endtask

   task automatic test_reset_mid_frame();
      send_frame(8'h12, 8'h34, 2, 2, "pre_reset");
      send(HDR, 2, 2, "mid_reset");
      send(8'h12, 2, 2, "mid_reset");
      send(8'h34, 2, 2, "mid_reset");
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      send(8'h83, 2, 2, "mid_reset");
      check_display("mid_reset");
      send_frame(8'h45, 8'h67, 2, 2, "post_reset");
      check_display("post_reset");
   endtask

   task automatic test_back_to_back();
      send_frame(8'h31, 8'h42, 1, 1, "b2b");
      send_frame(8'h99, 8'h99, 1, 1, "b2b");
      check_display("b2b");
   endtask

   task automatic test_random();
      logic [7:0] d0, d1, c, j;
      int hi, lo;
      for (int it = 0; it < 30; it++) begin
         hi = $urandom_range(1, 4);
         lo = $urandom_range(1, 10);
         if ($urandom_range(0, 3) == 0) begin
            j = 8'($urandom_range(0, 255));
            if (j == HDR) j = 8'h00;
            send(j, hi, lo, "rand_junk");
         end
         d0 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         d1 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         if ($urandom_range(0, 4) == 0) d1[3:0] = 4'($urandom_range(10, 15));
         c = HDR ^ d0 ^ d1;
         if ($urandom_range(0, 4) == 0) c = c ^ 8'($urandom_range(1, 255));
         send(HDR, hi, lo, "rand");
         send(d0, hi, lo, "rand");
         send(d1, hi, lo, "rand");
         send(c, hi, lo, "rand");
         if (it % 5 == 4) check_display("rand");
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_basic();
      test_errors();
      test_timeout();
      test_leading_zeros();
      test_reset_mid_frame();
      test_back_to_back();
      test_random();
      repeat (3) @(negedge clk);
      n_checks++;
      if (mon_ok != exp_ok_tot) begin
         n_fail++;
         $display("FAIL frame_ok total: %0d pulses, expected %0d", mon_ok, exp_ok_tot);
      end
      n_checks++;
      if (mon_err != exp_err_tot) begin
         n_fail++;
         $display("FAIL frame_err total: %0d pulses, expected %0d", mon_err, exp_err_tot);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
